signal_debounce: RTL and testbench
==================================

SIGNAL_DEBOUNCE -- requirements
Module: signal_debounce

Interface
REQ-001 The block SHALL have parameter ChNum, default 4, meaning the number of independent debounce channels.
REQ-002 The block SHALL have parameter CntWidth, default 8, meaning the width of each channel's tick counter.
REQ-003 The block SHALL have parameter DebounceVal, default 8'd20, meaning the number of TICK_EN pulses the input must stay stable (20 ticks of 1 ms = 20 ms); legal range is 1 to 2^CntWidth-1.
REQ-004 The block SHALL have port CLK_IN  input  1  system clock (2 MHz); the design has one clock, and all flops are rising-edge.
REQ-005 The block SHALL have port RESET_N  input  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have port TICK_EN  input  1  single-cycle time-base enable (1 kHz stage of the clock-enable generator), synchronous to CLK_IN.
REQ-007 The block SHALL have port SIG_IN  input  ChNum  raw asynchronous inputs (buttons, PWRGD, presence pins).
REQ-008 The block SHALL have port SIG_OUT  output  ChNum  debounced level per channel, registered.
REQ-009 The block SHALL have port RISE_O  output  ChNum  one-cycle pulse on a debounced 0->1 change (present only with SIGNAL_DEBOUNCE_EDGE_EN).
REQ-010 The block SHALL have port FALL_O  output  ChNum  one-cycle pulse on a debounced 1->0 change (present only with SIGNAL_DEBOUNCE_EDGE_EN).

Function
REQ-011 Each SIG_IN bit SHALL pass through a 2-flop synchronizer; the second-stage output is called s[i], and all logic below uses only s[i].
REQ-012 Each channel SHALL run an independent 2-state FSM: STABLE and WAIT.
REQ-013 In STABLE, when s[i] != SIG_OUT[i], the channel SHALL move to WAIT with cnt[i]=0; otherwise it stays in STABLE with cnt[i]=0.
REQ-014 In WAIT, when s[i] == SIG_OUT[i], the channel SHALL return to STABLE with cnt[i]=0 and SIG_OUT unchanged (glitch rejected).
REQ-015 In WAIT with s[i] != SIG_OUT[i] and TICK_EN=1, cnt[i] SHALL increment; with TICK_EN=0, cnt[i] SHALL hold.
REQ-016 In WAIT, when s[i] != SIG_OUT[i], TICK_EN=1 and cnt[i]==DebounceVal-1, the channel SHALL invert SIG_OUT[i] on that clock edge, clear cnt[i], and go to STABLE.
REQ-017 When the input returns to the SIG_OUT level in the same cycle as TICK_EN, the return SHALL take priority: no count and no output change.
REQ-018 The latency from an SIG_IN edge to the SIG_OUT change SHALL be 2 clocks (sync) + 1 clock, plus between DebounceVal-1 and DebounceVal tick periods.
REQ-019 cnt[i] SHALL never exceed DebounceVal-1 and SHALL never wrap.
REQ-020 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each complete per REQ-016 in the same cycle.
REQ-021 TICK_EN held high continuously SHALL be legal: the channel then behaves as a clock-cycle debouncer of DebounceVal cycles.

Reset
REQ-022 While RESET_N=0, the synchronizer flops, cnt, SIG_OUT, RISE_O and FALL_O SHALL be 0 and every FSM SHALL be in STABLE.
REQ-023 Reset asserted mid-WAIT SHALL abort the count immediately (asynchronously), with no output pulse.
REQ-024 After reset release, an input held high SHALL be reported only after the full debounce period per REQ-018.

Configuration
REQ-025 With macro SIGNAL_DEBOUNCE_EDGE_EN defined, RISE_O[i]/FALL_O[i] SHALL be registered, asserting for exactly one clock in the same cycle that SIG_OUT[i] becomes 1/0.
REQ-026 With SIGNAL_DEBOUNCE_EDGE_EN undefined, the RISE_O/FALL_O ports and their logic SHALL be absent, and SIG_OUT behaviour SHALL be identical.

Verification
REQ-027 The bench SHALL cover: DebounceVal=4, TICK_EN every 10 clocks, SIG_IN[0] 0->1 held -> SIG_OUT[0]=1 after 3-4 ticks (+3 clocks), with one RISE_O[0] pulse.
REQ-028 The bench SHALL cover: SIG_IN[1] high for 2 ticks then low -> SIG_OUT[1] stays 0, cnt cleared, and no pulse.
REQ-029 The bench SHALL cover: SIG_IN[0..3] all 0->1 in the same cycle -> all SIG_OUT bits set in the same cycle, with 4 RISE_O bits high for 1 clock.
REQ-030 The bench SHALL cover: input returning in the same cycle as TICK_EN at cnt=DebounceVal-1 -> no SIG_OUT change.
REQ-031 The bench SHALL cover: RESET_N pulsed low mid-WAIT with SIG_IN held 1 -> outputs 0 immediately, then SIG_OUT=1 a full period after release.
REQ-032 The bench SHALL cover: build without SIGNAL_DEBOUNCE_EDGE_EN and rerun REQ-027 -> identical SIG_OUT timing, with no edge ports present.

Source files
------------

// File: rtl/signal_debounce.sv
// Multi-channel input debouncer for slow board signals (buttons, PWRGD,
// presence pins). Each raw input is synchronised and must then hold its new
// level for DebounceVal consecutive TICK_EN pulses before SIG_OUT follows it.
//
// Optional feature macro: SIGNAL_DEBOUNCE_EDGE_EN
//   defined   -> RISE_O / FALL_O one-cycle pulses on debounced edges
//   undefined -> edge ports and logic absent, SIG_OUT unchanged
//
// Per-channel FSM:
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_STABLE | synced input matches SIG_OUT, counter parked at zero
//   ST_WAIT   | synced input differs from SIG_OUT, counting TICK_EN pulses
module signal_debounce #(
  parameter int                  ChNum       = 4,
  parameter int                  CntWidth    = 8,
  parameter logic [CntWidth-1:0] DebounceVal = CntWidth'(20)
) (
  input  logic             CLK_IN,
  input  logic             RESET_N,
  input  logic             TICK_EN,
  input  logic [ChNum-1:0] SIG_IN,
  output logic [ChNum-1:0] SIG_OUT
`ifdef SIGNAL_DEBOUNCE_EDGE_EN
  ,
  output logic [ChNum-1:0] RISE_O,
  output logic [ChNum-1:0] FALL_O
`endif
);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_WAIT   = 1'b1
  } state_t;

  // Count value on which the final qualifying tick flips the output.
  localparam logic [CntWidth-1:0] TermCnt = DebounceVal - 1'b1;

  logic [ChNum-1:0]    sync1;
  logic [ChNum-1:0]    sync2;
  logic [ChNum-1:0]    out_nxt;
  state_t              state     [ChNum];
  state_t              state_nxt [ChNum];
  logic [CntWidth-1:0] cnt       [ChNum];
  logic [CntWidth-1:0] cnt_nxt   [ChNum];

  // Two-flop synchroniser, FSM state, counters and debounced output.
  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1   <= '0;
      sync2   <= '0;
      SIG_OUT <= '0;
      for (int i = 0; i < ChNum; i++) begin
        state[i] <= ST_STABLE;
        cnt[i]   <= '0;
      end
    end else begin
      sync1   <= SIG_IN;
      sync2   <= sync1;
      SIG_OUT <= out_nxt;
      for (int i = 0; i < ChNum; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

  // Next-state, counter and output decisions for every channel.
  // A return to the SIG_OUT level is tested before the tick so that a
  // late glitch coinciding with the terminal tick is still rejected.
  always_comb begin
    out_nxt = SIG_OUT;
    for (int i = 0; i < ChNum; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      case (state[i])
        ST_STABLE: begin
          cnt_nxt[i] = '0;
          if (sync2[i] != SIG_OUT[i]) begin
            state_nxt[i] = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (sync2[i] == SIG_OUT[i]) begin
            state_nxt[i] = ST_STABLE;
            cnt_nxt[i]   = '0;
          end else if (TICK_EN) begin
            if (cnt[i] == TermCnt) begin
              out_nxt[i]   = ~SIG_OUT[i];
              cnt_nxt[i]   = '0;
              state_nxt[i] = ST_STABLE;
            end else begin
              cnt_nxt[i] = cnt[i] + 1'b1;
            end
          end
        end
        default: begin
          state_nxt[i] = ST_STABLE;
          cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

`ifdef SIGNAL_DEBOUNCE_EDGE_EN
  // Edge pulses registered alongside SIG_OUT so they line up with its change.
  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      RISE_O <= '0;
      FALL_O <= '0;
    end else begin
      RISE_O <= out_nxt & ~SIG_OUT;
      FALL_O <= ~out_nxt & SIG_OUT;
    end
  end
`endif

endmodule

// File: tb/tb_signal_debounce.sv
// Directed bench for signal_debounce with DebounceVal=4 and TICK_EN every
// 10 clocks. Builds with or without SIGNAL_DEBOUNCE_EDGE_EN.
//
// Latency reference: align() leaves the bench just after an edge that
// sampled TICK_EN=1. An input change made there is seen by the FSM three
// edges later, and the next ticks land 10, 20, 30 and 40 steps after the
// change. The fourth tick flips SIG_OUT, so the change is visible after
// exactly 40 steps. With TICK_EN held high, the same path takes 7 steps.
module tb_signal_debounce;

  logic       CLK_IN;
  logic       RESET_N;
  logic       TICK_EN;
  logic [3:0] SIG_IN;
  logic [3:0] SIG_OUT;
`ifdef SIGNAL_DEBOUNCE_EDGE_EN
  logic [3:0] RISE_O;
  logic [3:0] FALL_O;
  int         pulses;
`endif

  int n_chk;
  int n_bad;
  int phase;
  bit tick_always;

  signal_debounce #(
    .ChNum      (4),
    .CntWidth   (8),
    .DebounceVal(8'd4)
  ) dut (
    .CLK_IN (CLK_IN),
    .RESET_N(RESET_N),
    .TICK_EN(TICK_EN),
    .SIG_IN (SIG_IN),
    .SIG_OUT(SIG_OUT)
`ifdef SIGNAL_DEBOUNCE_EDGE_EN
    ,
    .RISE_O (RISE_O),
    .FALL_O (FALL_O)
`endif
  );

  initial CLK_IN = 1'b0;
  always #5 CLK_IN = ~CLK_IN;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Advance one clock, sample 1 ns later, then drive the next TICK_EN.
  task automatic step();
    @(posedge CLK_IN);
    #1;
    phase   = (phase == 9) ? 0 : phase + 1;
    TICK_EN = tick_always ? 1'b1 : (phase == 9);
`ifdef SIGNAL_DEBOUNCE_EDGE_EN
    pulses += $countones(RISE_O | FALL_O);
`endif
  endtask

  // Step until just after an edge that sampled TICK_EN=1.
  task automatic align();
    for (int i = 0; i < 10; i++) begin
      if (phase != 9) step();
    end
    step();
  endtask

  // Step until SIG_OUT changes (bounded), check latency and edge pulses.
  task automatic wait_change(input string tag, input int limit, input int lat_exp,
                             input logic [3:0] rise_exp, input logic [3:0] fall_exp);
    logic [3:0] prev;
    int         lat;
    prev = SIG_OUT;
    lat  = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (SIG_OUT !== prev) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'(lat_exp));
`ifdef SIGNAL_DEBOUNCE_EDGE_EN
    if (lat > 0) begin
      chk({tag, "_rise"}, 32'(RISE_O), 32'(rise_exp));
      chk({tag, "_fall"}, 32'(FALL_O), 32'(fall_exp));
      step();
      chk({tag, "_pulse_end"}, 32'(RISE_O | FALL_O), 32'd0);
    end
`else
    if (rise_exp === fall_exp && lat > limit) $display("unreachable");
`endif
  endtask

  initial begin
    n_chk       = 0;
    n_bad       = 0;
    phase       = 0;
    tick_always = 1'b0;
    RESET_N     = 1'b0;
    TICK_EN     = 1'b0;
    SIG_IN      = 4'h0;
`ifdef SIGNAL_DEBOUNCE_EDGE_EN
    pulses      = 0;
`endif

    // Reset state, with inputs active during reset.
    SIG_IN = 4'hF;
    repeat (8) step();
    chk("rst_sig_out", 32'(SIG_OUT), 32'h0);
`ifdef SIGNAL_DEBOUNCE_EDGE_EN
    chk("rst_edges", 32'(RISE_O | FALL_O), 32'h0);
`endif
    SIG_IN = 4'h0;
    step();
    RESET_N = 1'b1;
    repeat (5) step();
    chk("idle_sig_out", 32'(SIG_OUT), 32'h0);

    // Channel 0 rise and fall with a held input.
    align();
    SIG_IN[0] = 1'b1;
    wait_change("ch0_rise", 60, 40, 4'b0001, 4'b0000);
    chk("ch0_high", 32'(SIG_OUT), 32'h1);
    align();
    SIG_IN[0] = 1'b0;
    wait_change("ch0_fall", 60, 40, 4'b0000, 4'b0001);
    chk("ch0_low", 32'(SIG_OUT), 32'h0);

    // Channel 1 glitch of two ticks is rejected, then a full period is needed.
    align();
`ifdef SIGNAL_DEBOUNCE_EDGE_EN
    pulses = 0;
`endif
    SIG_IN[1] = 1'b1;
    repeat (25) step();
    SIG_IN[1] = 1'b0;
    wait_change("ch1_glitch", 60, -1, 4'b0000, 4'b0000);
    chk("ch1_glitch_out", 32'(SIG_OUT), 32'h0);
`ifdef SIGNAL_DEBOUNCE_EDGE_EN
    chk("ch1_glitch_pulses", 32'(pulses), 32'd0);
`endif
    align();
    SIG_IN[1] = 1'b1;
    wait_change("ch1_rise", 60, 40, 4'b0010, 4'b0000);
    chk("ch1_high", 32'(SIG_OUT), 32'h2);
    align();
    SIG_IN[1] = 1'b0;
    wait_change("ch1_fall", 60, 40, 4'b0000, 4'b0010);
    chk("ch1_low", 32'(SIG_OUT), 32'h0);

    // All channels change together and complete in the same cycle.
    align();
    SIG_IN = 4'hF;
    wait_change("all_rise", 60, 40, 4'b1111, 4'b0000);
    chk("all_high", 32'(SIG_OUT), 32'hF);
    align();
    SIG_IN = 4'h0;
    wait_change("all_fall", 60, 40, 4'b0000, 4'b1111);
    chk("all_low", 32'(SIG_OUT), 32'h0);

    // Channel 2 input returns exactly on the terminal tick: return wins.
    align();
    SIG_IN[2] = 1'b1;
    repeat (37) step();
    SIG_IN[2] = 1'b0;
    wait_change("ch2_late_return", 60, -1, 4'b0000, 4'b0000);
    chk("ch2_late_out", 32'(SIG_OUT), 32'h0);

    // Reset mid-WAIT on channel 3 while channel 0 is already high.
    align();
    SIG_IN[0] = 1'b1;
    wait_change("pre_rst_rise", 60, 40, 4'b0001, 4'b0000);
    align();
    SIG_IN[3] = 1'b1;
    repeat (25) step();
    #2;
    RESET_N = 1'b0;
    #1;
    chk("rst_async_out", 32'(SIG_OUT), 32'h0);
`ifdef SIGNAL_DEBOUNCE_EDGE_EN
    chk("rst_async_edges", 32'(RISE_O | FALL_O), 32'h0);
`endif
    repeat (3) step();
    chk("rst_hold_out", 32'(SIG_OUT), 32'h0);
    align();
    RESET_N = 1'b1;
    wait_change("post_rst", 60, 40, 4'b1001, 4'b0000);
    chk("post_rst_out", 32'(SIG_OUT), 32'h9);

    // TICK_EN held high: debounce in DebounceVal clock cycles.
    tick_always = 1'b1;
    TICK_EN     = 1'b1;
    SIG_IN[3]   = 1'b0;
    wait_change("cont_tick", 20, 7, 4'b0000, 4'b1000);
    chk("cont_tick_out", 32'(SIG_OUT), 32'h1);
    tick_always = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
